// File: rtl/otter_timer_pkg.sv
// Shared definitions for the OTTER I/O-bus timer.
//   - word offsets of the four registers inside the 16-byte window
//   - bit positions of the CTRL and STATUS fields
//   - ctrl_t: packed image of the CTRL register (reserved fields always 0)
//   - ctrl_from_word(): builds a ctrl_t from a CPU store word, keeping only
//     the EN, AUTO, IRQ_EN and PRESCALE fields
package otter_timer_pkg;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_COUNT   = 2'd1;
  localparam logic [1:0] REG_COMPARE = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_AUTO_BIT   = 1;
  localparam int CTRL_IRQ_EN_BIT = 2;
  localparam int CTRL_PS_LSB     = 8;
  localparam int CTRL_PS_MSB     = 15;

  localparam int STATUS_PEND_BIT = 0;
  localparam int STATUS_OVF_BIT  = 1;

  typedef struct packed {
    logic [15:0] rsvd_hi;
    logic [7:0]  prescale;
    logic [4:0]  rsvd_lo;
    logic        irq_en;
    logic        auto_reload;
    logic        en;
  } ctrl_t;

  function automatic ctrl_t ctrl_from_word(input logic [31:0] word);
    ctrl_t c;
    c             = '0;
    c.en          = word[CTRL_EN_BIT];
    c.auto_reload = word[CTRL_AUTO_BIT];
    c.irq_en      = word[CTRL_IRQ_EN_BIT];
    c.prescale    = word[CTRL_PS_MSB:CTRL_PS_LSB];
    return c;
  endfunction

endpackage

// File: rtl/otter_timer_prescaler.sv
// Prescaler for the OTTER I/O-bus timer.
//   clk      : clock
//   rst_n    : asynchronous active-low reset
//   en       : timer enable; while low the counter holds at 0
//   clr      : forces the counter back to 0 at the next edge
//   prescale : terminal count; a tick fires every prescale+1 enabled cycles
//   tick     : one-cycle pulse, combinational from the counter state
module otter_timer_prescaler (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  input  logic [7:0] prescale,
  output logic       tick
);

  logic [7:0] ps_reg;
  logic [7:0] ps_next;

  // The tick is raised in the cycle where the counter sits at the terminal
  // value, so prescale=0 yields a tick on every enabled cycle.
  assign tick = en && (ps_reg == prescale);

  always_comb begin
    ps_next = ps_reg + 8'd1;
    if (clr || !en || tick) begin
      ps_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_reg <= '0;
    end else begin
      ps_reg <= ps_next;
    end
  end

endmodule

// File: rtl/otter_iobus_timer.sv
// Memory-mapped compare timer on the OTTER I/O bus.
//   BASE_ADDR  : base of the 16-byte register window (bits [3:0] zero)
//   CLK        : clock
//   RESET_N    : asynchronous active-low reset
//   IOBUS_ADDR : byte address; [31:4] selects the window, [3:2] the register
//   IOBUS_OUT  : store data
//   IOBUS_WR   : store strobe
//   IOBUS_IN   : combinational read data, 0 outside the window
//   INTR       : level interrupt, PEND & IRQ_EN
// Registers: 0x0 CTRL, 0x4 COUNT, 0x8 COMPARE, 0xC STATUS (W1C).
module otter_iobus_timer
  import otter_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1100_0100
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  output logic        INTR
);

  ctrl_t       ctrl_reg, ctrl_next;
  logic [31:0] count_reg, count_next;
  logic [31:0] compare_reg, compare_next;
  logic [1:0]  status_reg, status_next;

  logic        hit;
  logic [1:0]  sel;
  logic [3:0]  wr_sel;
  logic        tick;
  logic        match_tick;
  logic        unused_addr_bits;

  assign hit = (IOBUS_ADDR[31:4] == BASE_ADDR[31:4]);
  assign sel = IOBUS_ADDR[3:2];

  // Byte lane bits play no part in decoding.
  assign unused_addr_bits = ^IOBUS_ADDR[1:0];

  // One write strobe per register.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_wr_sel
      assign wr_sel[gi] = IOBUS_WR && hit && (sel == 2'(gi));
    end
  endgenerate

  otter_timer_prescaler u_prescaler (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .en       (ctrl_reg.en),
    .clr      (wr_sel[REG_CTRL]),
    .prescale (ctrl_reg.prescale),
    .tick     (tick)
  );

  assign match_tick = tick && (count_reg == compare_reg);

  always_comb begin
    ctrl_next    = ctrl_reg;
    count_next   = count_reg;
    compare_next = compare_reg;
    status_next  = status_reg;

    // Hardware effects first; CPU writes below override them.
    if (tick) begin
      count_next = match_tick ? 32'd0 : count_reg + 32'd1;
    end
    if (match_tick && !ctrl_reg.auto_reload) begin
      ctrl_next.en = 1'b0;
    end

    if (wr_sel[REG_CTRL]) begin
      ctrl_next = ctrl_from_word(IOBUS_OUT);
    end
    if (wr_sel[REG_COUNT]) begin
      count_next = IOBUS_OUT;
    end
    if (wr_sel[REG_COMPARE]) begin
      compare_next = IOBUS_OUT;
    end

    // W1C clear is applied before the hardware set so a coincident set wins.
    // OVF looks at PEND as it was before this edge.
    if (wr_sel[REG_STATUS]) begin
      status_next = status_reg & ~IOBUS_OUT[1:0];
    end
    if (match_tick) begin
      status_next[STATUS_PEND_BIT] = 1'b1;
      if (status_reg[STATUS_PEND_BIT]) begin
        status_next[STATUS_OVF_BIT] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ctrl_reg    <= '0;
      count_reg   <= '0;
      compare_reg <= '0;
      status_reg  <= '0;
    end else begin
      ctrl_reg    <= ctrl_next;
      count_reg   <= count_next;
      compare_reg <= compare_next;
      status_reg  <= status_next;
    end
  end

  always_comb begin
    IOBUS_IN = '0;
    if (hit) begin
      case (sel)
        REG_CTRL:    IOBUS_IN = ctrl_reg;
        REG_COUNT:   IOBUS_IN = count_reg;
        REG_COMPARE: IOBUS_IN = compare_reg;
        default:     IOBUS_IN = {30'd0, status_reg};
      endcase
    end
  end

  assign INTR = status_reg[STATUS_PEND_BIT] && ctrl_reg.irq_en;

endmodule

// File: tb/tb_otter_iobus_timer.sv
// Self-checking bench for otter_iobus_timer: directed scenarios with literal
// expectations, then randomized bus traffic compared every cycle against a
// behavioural model of the register set.
module tb_otter_iobus_timer;

  localparam logic [31:0] BASE = 32'h1100_0100;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [31:0] IOBUS_ADDR = BASE;
  logic [31:0] IOBUS_OUT = '0;
  logic        IOBUS_WR = 1'b0;
  logic [31:0] IOBUS_IN;
  logic        INTR;

  int checks = 0;
  int errors = 0;

  otter_iobus_timer #(.BASE_ADDR(BASE)) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .IOBUS_ADDR (IOBUS_ADDR),
    .IOBUS_OUT  (IOBUS_OUT),
    .IOBUS_WR   (IOBUS_WR),
    .IOBUS_IN   (IOBUS_IN),
    .INTR       (INTR)
  );

  always #5 CLK = ~CLK;

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        en;
    logic        auto_r;
    logic        irq;
    logic [7:0]  pre;
    logic [7:0]  ps;       // enabled cycles since the last tick
    logic [31:0] count;
    logic [31:0] compare;
    logic        pend;
    logic        ovf;
  } model_t;

  model_t m;

  function automatic model_t model_step(model_t s, logic [31:0] a, logic [31:0] d, logic w);
    model_t n = s;
    logic   tk, mt, wr;
    wr = w && (a[31:4] == BASE[31:4]);
    tk = s.en && (s.ps == s.pre);
    mt = tk && (s.count == s.compare);
    n.ps = (s.en && !tk) ? s.ps + 8'd1 : 8'd0;
    if (tk) n.count = mt ? 32'd0 : s.count + 32'd1;
    if (mt) begin
      n.pend = 1'b1;
      if (s.pend) n.ovf = 1'b1;
      if (!s.auto_r) n.en = 1'b0;
    end
    if (wr) begin
      case (a[3:2])
        2'd0: begin
          n.en = d[0]; n.auto_r = d[1]; n.irq = d[2]; n.pre = d[15:8]; n.ps = 8'd0;
        end
        2'd1: n.count = d;
        2'd2: n.compare = d;
        default: begin
          if (d[0] && !mt) n.pend = 1'b0;
          if (d[1] && !(mt && s.pend)) n.ovf = 1'b0;
        end
      endcase
    end
    return n;
  endfunction

  function automatic logic [31:0] model_read(model_t s, logic [31:0] a);
    if (a[31:4] != BASE[31:4]) return 32'd0;
    case (a[3:2])
      2'd0:    return {16'd0, s.pre, 5'd0, s.irq, s.auto_r, s.en};
      2'd1:    return s.count;
      2'd2:    return s.compare;
      default: return {30'd0, s.ovf, s.pend};
    endcase
  endfunction

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) m <= '0;
    else          m <= model_step(m, IOBUS_ADDR, IOBUS_OUT, IOBUS_WR);
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h expected=%08h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic cmp_model();
    check("model_rdata", IOBUS_IN, model_read(m, IOBUS_ADDR));
    check("model_intr", {31'd0, INTR}, {31'd0, m.pend & m.irq});
  endtask

  // One bus cycle: drive just after the edge, compare 1 time unit later.
  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w);
    @(posedge CLK);
    #1;
    IOBUS_ADDR = a;
    IOBUS_OUT  = d;
    IOBUS_WR   = w;
    #1;
    cmp_model();
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] d);
    $display("WR  off=%h data=%08h", off, d);
    drive(BASE + {28'd0, off}, d, 1'b1);
  endtask

  task automatic rd(input logic [3:0] off);
    drive(BASE + {28'd0, off}, $urandom, 1'b0);
    $display("RD  off=%h data=%08h intr=%0b", off, IOBUS_IN, INTR);
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #3;
    RESET_N  = 1'b0;
    IOBUS_WR = 1'b0;
    #1;
    cmp_model();
    @(posedge CLK);
    #3;
    RESET_N = 1'b1;
    #1;
    cmp_model();
    $display("RST");
  endtask

  initial begin
    logic [31:0] d;
    logic [3:0]  off;
    int          op;

    // Reset state
    repeat (2) @(posedge CLK);
    #3;
    RESET_N = 1'b1;
    rd(4'h0); check("reset_ctrl", IOBUS_IN, 32'h0);
    rd(4'h4); check("reset_count", IOBUS_IN, 32'h0);
    rd(4'hC); check("reset_status", IOBUS_IN, 32'h0);
    check("reset_intr", {31'd0, INTR}, 32'h0);

    // Auto-reload with prescale 0: 0,1,2,3,0 and INTR after the match
    do_reset();
    wr(4'h8, 32'd3);
    wr(4'h0, 32'h7);
    for (int k = 0; k < 5; k++) begin
      rd(4'h4);
      check("auto_count", IOBUS_IN, (k == 4) ? 32'd0 : 32'(k));
      check("auto_intr", {31'd0, INTR}, (k == 4) ? 32'd1 : 32'd0);
    end
    rd(4'h0); check("auto_ctrl_en_kept", IOBUS_IN, 32'h7);

    // One-shot
    do_reset();
    wr(4'h8, 32'd2);
    wr(4'h0, 32'h5);
    for (int k = 0; k < 3; k++) begin
      rd(4'h4); check("oneshot_count", IOBUS_IN, 32'(k));
    end
    rd(4'h0); check("oneshot_ctrl", IOBUS_IN, 32'h4);
    rd(4'h4); check("oneshot_count0", IOBUS_IN, 32'h0);
    rd(4'h4); check("oneshot_hold", IOBUS_IN, 32'h0);
    rd(4'hC); check("oneshot_status", IOBUS_IN, 32'h1);
    check("oneshot_intr", {31'd0, INTR}, 32'h1);
    wr(4'hC, 32'h1);
    check("oneshot_intr_wrcycle", {31'd0, INTR}, 32'h1);
    rd(4'hC); check("oneshot_status_clr", IOBUS_IN, 32'h0);
    check("oneshot_intr_drop", {31'd0, INTR}, 32'h0);

    // Prescale 4: tick every 5 cycles, second match sets OVF
    do_reset();
    wr(4'h8, 32'd1);
    wr(4'h0, 32'h0000_0403);
    for (int k = 0; k < 21; k++) begin
      rd(4'h4); check("ps4_count", IOBUS_IN, 32'((k / 5) % 2));
    end
    rd(4'hC); check("ps4_status", IOBUS_IN, 32'h3);

    // COUNT write wins over a coincident tick
    do_reset();
    wr(4'h8, 32'd100);
    wr(4'h0, 32'h3);
    rd(4'h4); check("cw_count0", IOBUS_IN, 32'd0);
    rd(4'h4); check("cw_count1", IOBUS_IN, 32'd1);
    wr(4'h4, 32'h1234);
    rd(4'h4); check("cw_count_wr", IOBUS_IN, 32'h1234);

    // W1C coincident with a match leaves PEND set (and OVF sets)
    do_reset();
    wr(4'h8, 32'd2);
    wr(4'h0, 32'h3);
    repeat (5) rd(4'h4);
    wr(4'hC, 32'h1);
    rd(4'hC); check("w1c_vs_set", IOBUS_IN, 32'h3);

    // Asynchronous reset mid-count
    do_reset();
    wr(4'h8, 32'd100);
    wr(4'h0, 32'h7);
    for (int k = 0; k < 8; k++) begin
      rd(4'h4); check("rst_precount", IOBUS_IN, 32'(k));
    end
    #1;
    RESET_N = 1'b0;
    for (int k = 0; k < 4; k++) begin
      IOBUS_ADDR = BASE + 32'(k * 4);
      #1;
      check("rst_async_reg", IOBUS_IN, 32'h0);
    end
    check("rst_async_intr", {31'd0, INTR}, 32'h0);
    IOBUS_ADDR = BASE + 32'h10;
    #1;
    check("rst_miss_read", IOBUS_IN, 32'h0);
    @(posedge CLK);
    #3;
    RESET_N = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      op  = $urandom_range(0, 199);
      off = 4'($urandom_range(0, 3) * 4 + $urandom_range(0, 3));
      d   = $urandom;
      case (off[3:2])
        2'd0: begin
          d[15:8] = 8'($urandom_range(0, 3));
          d[0]    = ($urandom_range(0, 3) != 0);
        end
        2'd1: begin
          if ($urandom_range(0, 1) == 0) d = 32'($urandom_range(0, 10));
          else if ($urandom_range(0, 1) == 0) d = 32'hFFFF_FFFF - 32'($urandom_range(0, 4));
        end
        2'd2: if ($urandom_range(0, 3) != 0) d = 32'($urandom_range(0, 12));
        default: ;
      endcase
      if (op < 2) begin
        do_reset();
      end else if (op < 20) begin
        drive((op < 10) ? BASE + 32'h10 + {28'd0, off} : $urandom, d, $urandom_range(0, 1) == 1);
      end else if (op < 45) begin
        wr(off, d);
      end else begin
        rd(off);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/otter_iobus_timer.md
OTTER_IOBUS_TIMER -- requirements
Module: otter_iobus_timer

Interface
REQ-001 Parameter BASE_ADDR, 32'h1100_0100, base of the 16-byte register window; bits [3:0] SHALL be zero.
REQ-002 CLK  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 RESET_N  input  1  asynchronous, active-low reset.
REQ-004 IOBUS_ADDR  input  32  byte address from the CPU memory stage.
REQ-005 IOBUS_OUT  input  32  CPU store data.
REQ-006 IOBUS_WR  input  1  store strobe, one cycle per store.
REQ-007 IOBUS_IN  output  32  read data returned to the CPU.
REQ-008 INTR  output  1  level interrupt to the CPU.

Function
REQ-009 A hit SHALL be IOBUS_ADDR[31:4]==BASE_ADDR[31:4]; the register is selected by IOBUS_ADDR[3:2]; IOBUS_ADDR[1:0] SHALL be ignored.
REQ-010 Register map: 0x0 CTRL (bit0 EN, bit1 AUTO, bit2 IRQ_EN, [15:8] PRESCALE); 0x4 COUNT; 0x8 COMPARE; 0xC STATUS (bit0 PEND, bit1 OVF).
REQ-011 Unused CTRL bits and STATUS[31:2] SHALL read 0 and ignore writes.
REQ-012 IOBUS_IN SHALL be combinational from the selected register; it SHALL be 0 on a miss.
REQ-013 A write SHALL occur when IOBUS_WR=1 and the address hits; the register updates at that edge.
REQ-014 STATUS writes SHALL be write-1-to-clear per bit.
REQ-015 Prescaler: 8-bit counter PS; when EN=1, PS SHALL increment each cycle; when PS==PRESCALE, PS SHALL reset to 0 and raise a one-cycle tick.
REQ-016 With PRESCALE=0, tick SHALL assert every cycle while EN=1.
REQ-017 When EN=0, PS SHALL hold at 0 and no tick SHALL occur.
REQ-018 Any CTRL write SHALL clear PS to 0.
REQ-019 On a tick with COUNT!=COMPARE, COUNT SHALL increment modulo 2^32 (0xFFFF_FFFF wraps to 0 with no flag).
REQ-020 On a tick with COUNT==COMPARE:
- PEND SHALL set.
- If PEND was already 1, OVF SHALL set.
- COUNT SHALL become 0.
- If AUTO=0, EN SHALL clear (one-shot).
REQ-021 A CPU write to COUNT in a tick cycle SHALL win over the increment or reload.
REQ-022 A CPU write to CTRL in a match cycle SHALL win over the one-shot EN clear.
REQ-023 A STATUS W1C coinciding with a hardware set of the same bit SHALL leave the bit set.
REQ-024 INTR SHALL equal PEND & IRQ_EN. Latency: asserts in the cycle after the match-tick edge and deasserts in the cycle after the clearing write.

Reset
REQ-025 RESET_N=0 SHALL asynchronously clear CTRL, COUNT, COMPARE, STATUS and PS to 0, forcing INTR=0 and a disabled timer.
REQ-026 Reset deassertion SHALL be synchronised externally; no write SHALL be lost in the first cycle after release.
REQ-027 Reset during counting SHALL abandon the pending tick; no PEND SHALL result.

Structure
REQ-028 Package otter_timer_pkg SHALL hold the register offset constants, the CTRL and STATUS bit-position constants, and a packed struct typedef for CTRL.
REQ-029 The prescaler SHALL be the sub-module otter_timer_prescaler (inputs en, clr, prescale[7:0]; output tick); all other logic is flat in otter_iobus_timer.

Verification
REQ-030 Set COMPARE=3, then CTRL=0x7 (PRESCALE=0) -> COUNT reads 0,1,2,3,0; INTR rises on the edge after the tick at COUNT==3; EN stays 1.
REQ-031 One-shot: COMPARE=2, CTRL=0x5 -> after the match, EN=0, COUNT=0 and holds; STATUS=0x1; writing STATUS=0x1 drops INTR the next cycle.
REQ-032 PRESCALE=4, COMPARE=1, AUTO=1, EN=1 -> a tick every 5 cycles; a second match without clearing gives STATUS=0x3.
REQ-033 Write COUNT=0x1234 in the same cycle as a tick -> COUNT reads 0x1234, not an increment.
REQ-034 STATUS W1C in the same cycle as a match -> PEND remains 1.
REQ-035 Assert RESET_N=0 mid-count with COUNT=7 -> all registers read 0 immediately; INTR=0; a read at BASE_ADDR+0x10 returns 0.
